// File: rtl/spike_window_monitor.sv
// spike_window_monitor
// Counts rising edges on four spike lines over fixed windows of WINDOW_CYCLES
// clocks, then latches the counts, a saturation flag and a winner index
// together with a one-cycle window_valid strobe.
//
// Ports:
//   clk          system clock
//   reset        synchronous reset, active-high
//   enable       1 = run back-to-back windows, 0 = abort and idle
//   spike_in     [0]=spike_1 [1]=spike_2 [2]=spike_3 [3]=spike_output
//   count_1..3   latched edge counts of spike_in[0..2]
//   count_out    latched edge count of spike_in[3]
//   winner       1..3 = input line with unique highest count, 0 = none
//   overflow     a counter saturated during the latched window
//   window_valid one-cycle strobe when new results appear
module spike_window_monitor #(
   parameter int unsigned WINDOW_CYCLES = 256,
   parameter int unsigned CNT_W         = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [3:0]       spike_in,
   output logic [CNT_W-1:0] count_1,
   output logic [CNT_W-1:0] count_2,
   output logic [CNT_W-1:0] count_3,
   output logic [CNT_W-1:0] count_out,
   output logic [1:0]       winner,
   output logic             overflow,
   output logic             window_valid
);

   localparam int unsigned      TMR_W    = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_next;
   logic [TMR_W-1:0] timer;
   logic [CNT_W-1:0] acc      [4];
   logic [CNT_W-1:0] acc_next [4];
   logic [3:0]       prev;
   logic [3:0]       events;
   logic             ovf_acc, ovf_next;
   logic             run, window_end;
   logic [1:0]       winner_next;

   // FSM: state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // FSM: next state
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (enable)  state_next = RUN;
         RUN:     if (!enable) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM: outputs. A RUN cycle with enable low is an abort, so it neither
   // accumulates nor can close a window.
   always_comb begin
      run        = (state == RUN) && enable;
      window_end = run && (timer == TMR_LAST);
   end

   // Saturating accumulation of this cycle's rising edges
   always_comb begin
      events   = spike_in & ~prev;
      ovf_next = ovf_acc;
      for (int unsigned i = 0; i < 4; i++) begin
         acc_next[i] = acc[i];
         if (events[i]) begin
            if (acc[i] == CNT_MAX) ovf_next    = 1'b1;
            else                   acc_next[i] = acc[i] + 1'b1;
         end
      end
   end

   // Strictly-largest of the three input counts; ties and all-zero give 0
   always_comb begin
      winner_next = 2'd0;
      if      ((acc_next[0] > acc_next[1]) && (acc_next[0] > acc_next[2])) winner_next = 2'd1;
      else if ((acc_next[1] > acc_next[0]) && (acc_next[1] > acc_next[2])) winner_next = 2'd2;
      else if ((acc_next[2] > acc_next[0]) && (acc_next[2] > acc_next[1])) winner_next = 2'd3;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev         <= '0;
         timer        <= '0;
         ovf_acc      <= 1'b0;
         for (int unsigned i = 0; i < 4; i++) acc[i] <= '0;
         count_1      <= '0;
         count_2      <= '0;
         count_3      <= '0;
         count_out    <= '0;
         winner       <= 2'd0;
         overflow     <= 1'b0;
         window_valid <= 1'b0;
      end else begin
         prev         <= spike_in;
         window_valid <= 1'b0;
         if (!run) begin
            timer   <= '0;
            ovf_acc <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) acc[i] <= '0;
         end else if (window_end) begin
            // Latch final values; next window starts on the following cycle
            count_1      <= acc_next[0];
            count_2      <= acc_next[1];
            count_3      <= acc_next[2];
            count_out    <= acc_next[3];
            winner       <= winner_next;
            overflow     <= ovf_next;
            window_valid <= 1'b1;
            timer        <= '0;
            ovf_acc      <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) acc[i] <= '0;
         end else begin
            timer   <= timer + 1'b1;
            ovf_acc <= ovf_next;
            for (int unsigned i = 0; i < 4; i++) acc[i] <= acc_next[i];
         end
      end
   end

endmodule
